// File: rtl/risc_pkg.sv
// Shared definitions for the RISC multi-cycle sequencer family.
//   seq_state_t      : sequencer state encoding (also exported for debug)
//   XLEN_DEF         : default datapath / address width
//   PC_STEP_DEF      : default sequential PC increment
//   RESET_PC_DEF     : default PC after reset
//   IRQ_VECTOR_DEF   : default PC loaded on interrupt entry
package risc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_IRQ    = 3'd6
  } seq_state_t;

  localparam int          XLEN_DEF       = 32;
  localparam int          PC_STEP_DEF    = 4;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] IRQ_VECTOR_DEF = 32'h0000_0100;

endpackage

// File: rtl/risc_next_pc.sv
// Combinational next-PC select shared by the multi-cycle sequencer and the
// pipelined front end.
//   pc_i        : address of the current instruction
//   epc_i       : saved interrupt return address
//   br_target_i : branch / jump destination
//   iret_i      : current instruction is a return-from-interrupt
//   br_taken_i  : branch condition resolved taken
//   next_pc_o   : iret -> epc, else taken branch -> target, else pc + PC_STEP
module risc_next_pc
  import risc_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            iret_i,
  input  logic            br_taken_i,
  output logic [XLEN-1:0] next_pc_o
);

  always_comb begin
    if (iret_i) begin
      next_pc_o = epc_i;
    end else if (br_taken_i) begin
      next_pc_o = br_target_i;
    end else begin
      // Wraps naturally modulo 2^XLEN.
      next_pc_o = pc_i + XLEN'(PC_STEP);
    end
  end

endmodule

// File: rtl/risc_mc_sequencer.sv
// Multi-cycle instruction sequencer: owns PC, IR, memory handshakes, the
// register-file write strobe, halt, a single-level interrupt and the retire
// counter. Decode, register bank, ALU and branch logic are external.
//   clk, reset               : clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata  : instruction fetch handshake
//   dmem_req/we/ack          : data access handshake
//   dec_*, br_taken, br_target : decoded controls for the latched ir
//   irq                      : level interrupt request
//   ir, pc, epc, ie          : architectural sequencer state
//   rf_we, irq_ack, halted   : state-decoded strobes
//   instret                  : retired-instruction count
//   state_o                  : current FSM state for debug
//
// Handshake: a request (imem_req / dmem_req) is held high, with address and
// write-enable stable, until the responder returns ack in the same cycle; the
// transfer completes on that rising edge. Ack while req is low is ignored.
module risc_mc_sequencer
  import risc_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] IRQ_VECTOR = XLEN'(IRQ_VECTOR_DEF),
  parameter int              PC_STEP    = PC_STEP_DEF,
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             dec_mem_rd,
  input  logic             dec_mem_wr,
  input  logic             dec_wb,
  input  logic             dec_halt,
  input  logic             dec_iret,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  input  logic             irq,
  output logic [XLEN-1:0]  ir,
  output logic [XLEN-1:0]  pc,
  output logic             rf_we,
  output logic             irq_ack,
  output logic [XLEN-1:0]  epc,
  output logic             ie,
  output logic             halted,
  output logic [CNT_W-1:0] instret,
  output seq_state_t       state_o
);

  seq_state_t       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic             ie_q, ie_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]  next_pc;
  logic             retire;

  risc_next_pc #(
    .XLEN    (XLEN),
    .PC_STEP (PC_STEP)
  ) u_next_pc (
    .pc_i        (pc_q),
    .epc_i       (epc_q),
    .br_target_i (br_target),
    .iret_i      (dec_iret),
    .br_taken_i  (br_taken),
    .next_pc_o   (next_pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      epc_q     <= '0;
      ie_q      <= 1'b1;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      epc_q     <= epc_d;
      ie_q      <= ie_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    epc_d     = epc_q;
    ie_d      = ie_q;
    instret_d = instret_q;
    retire    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (dec_halt) begin
          state_d = S_HALT;
        end else if (dec_mem_rd || dec_mem_wr) begin
          state_d = S_MEM;
        end else if (dec_wb) begin
          state_d = S_WB;
        end else begin
          retire = 1'b1;
        end
      end
      S_MEM: begin
        // A combined read+write performs the write, then writes back.
        if (dmem_ack) begin
          if (dec_mem_rd) state_d = S_WB;
          else            retire  = 1'b1;
        end
      end
      S_WB: retire = 1'b1;
      S_HALT: begin
        // pc is advanced here so the IRQ state saves halt address + step.
        if (irq && ie_q) begin
          pc_d    = pc_q + XLEN'(PC_STEP);
          state_d = S_IRQ;
        end
      end
      S_IRQ: begin
        // pc already holds the return address computed at retirement.
        epc_d   = pc_q;
        pc_d    = IRQ_VECTOR;
        ie_d    = 1'b0;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
      pc_d      = next_pc;
      if (dec_iret) ie_d = 1'b1;
      // An iret never re-enters immediately, even with irq pending.
      if (irq && ie_q && !dec_iret) state_d = S_IRQ;
      else                          state_d = S_FETCH;
    end
  end

  // The fetch request is gated by reset so it stays low while held in reset.
  assign imem_req  = (state_q == S_FETCH) && reset;
  assign imem_addr = pc_q;
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = (state_q == S_MEM) && dec_mem_wr;
  assign rf_we     = (state_q == S_WB);
  assign irq_ack   = (state_q == S_IRQ);
  assign halted    = (state_q == S_HALT);
  assign ir        = ir_q;
  assign pc        = pc_q;
  assign epc       = epc_q;
  assign ie        = ie_q;
  assign instret   = instret_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_risc_mc_sequencer.sv
module tb_risc_mc_sequencer;
  import risc_pkg::*;

  localparam logic [31:0] IRQ_VEC = 32'h0000_0100;

  typedef struct {
    logic        rd, wr, wb, halt, iret, br;
    logic [31:0] target;
    int          iw, dw;
    logic        irq;
  } ins_t;

  typedef struct {
    ins_t        ins;
    int          e_cyc, e_rf, e_ack;
    logic [31:0] e_pc;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack, dmem_ack;
  logic [31:0] imem_rdata, br_target;
  logic        dec_mem_rd, dec_mem_wr, dec_wb, dec_halt, dec_iret, br_taken, irq;

  logic        imem_req, dmem_req, dmem_we, rf_we, irq_ack, ie, halted;
  logic [31:0] imem_addr, ir, pc, epc, instret;
  seq_state_t  state_dbg;

  logic        w_imem_req, w_dmem_req, w_dmem_we, w_rf_we, w_irq_ack, w_ie, w_halted;
  logic [31:0] w_imem_addr, w_ir, w_pc, w_epc;
  logic [1:0]  w_instret;
  seq_state_t  w_state;

  always #5 clk = ~clk;

  risc_mc_sequencer dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_wb(dec_wb), .dec_halt(dec_halt),
    .dec_iret(dec_iret), .br_taken(br_taken), .br_target(br_target), .irq(irq),
    .ir(ir), .pc(pc), .rf_we(rf_we), .irq_ack(irq_ack), .epc(epc), .ie(ie),
    .halted(halted), .instret(instret), .state_o(state_dbg)
  );

  // Narrow retire counter copy, used to observe wrap-around.
  risc_mc_sequencer #(.CNT_W(2)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_ack(dmem_ack),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_wb(dec_wb), .dec_halt(dec_halt),
    .dec_iret(dec_iret), .br_taken(br_taken), .br_target(br_target), .irq(irq),
    .ir(w_ir), .pc(w_pc), .rf_we(w_rf_we), .irq_ack(w_irq_ack), .epc(w_epc), .ie(w_ie),
    .halted(w_halted), .instret(w_instret), .state_o(w_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc, m_epc, m_instret;
  logic        m_ie;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_ie = 1'b1; m_instret = 32'h0;
    exp_q.delete();
    exp_q.push_back(32'h0);
  endtask

  // Architectural effect of one instruction plus its expected cost.
  task automatic model_step(input ins_t t, output int e_cyc, output int e_rf,
                            output int e_ack, output int e_dreq);
    logic [31:0] nxt;
    bit mem, wbp, entry;
    mem   = t.rd | t.wr;
    wbp   = mem ? t.rd : t.wb;
    if (t.halt) begin
      e_cyc = 3 + t.iw; e_rf = 0; e_ack = 0; e_dreq = 0;
    end else begin
      if (t.iret)    nxt = m_epc;
      else if (t.br) nxt = t.target;
      else           nxt = m_pc + 32'd4;
      entry = t.irq && m_ie && !t.iret;
      if (t.iret) m_ie = 1'b1;
      m_instret = m_instret + 32'd1;
      e_dreq = mem ? 1 + t.dw : 0;
      e_cyc  = 3 + t.iw + e_dreq + (wbp ? 1 : 0) + (entry ? 1 : 0);
      e_rf   = wbp ? 1 : 0;
      e_ack  = entry ? 1 : 0;
      if (entry) begin
        m_epc = nxt; m_pc = IRQ_VEC; m_ie = 1'b0;
      end else begin
        m_pc = nxt;
      end
      exp_q.push_back(m_pc);
    end
  endtask

  // ---------------- driver ----------------
  // Entered at a falling edge with the DUT in FETCH; returns at the falling
  // edge where the DUT is back in FETCH or halted.
  task automatic run_instr(input ins_t t, output int cyc, output int rf_n,
                           output int ack_n, output int dreq_n);
    logic [31:0] word, exp_addr;
    int dseen;
    bit done;
    cyc = 0; rf_n = 0; ack_n = 0; dreq_n = 0; dseen = 0; done = 1'b0;
    word = $urandom;
    dec_mem_rd = t.rd; dec_mem_wr = t.wr; dec_wb = t.wb; dec_halt = t.halt;
    dec_iret = t.iret; br_taken = t.br; br_target = t.target; irq = t.irq;
    dmem_ack = 1'b0;
    if (exp_q.size() > 0) begin
      exp_addr = exp_q.pop_front();
      chk("fetch_addr", 64'(imem_addr), 64'(exp_addr));
    end else begin
      n_checks++; n_err++;
      $display("FAIL sb_empty: got fetch at %0h expected no fetch", imem_addr);
    end
    chk("fetch_req", 64'(imem_req), 64'(1'b1));
    for (int w = 0; w < t.iw; w++) begin
      imem_ack = 1'b0; imem_rdata = $urandom;
      @(negedge clk); cyc++;
      chk("fetch_hold", 64'(imem_req), 64'(1'b1));
    end
    imem_ack = 1'b1; imem_rdata = word;
    @(negedge clk); cyc++;
    imem_ack = 1'b0;
    chk("ir_latch", 64'(ir), 64'(word));
    for (int k = 0; k < 64 && !done; k++) begin
      if (imem_req || halted) begin
        done = 1'b1;
      end else begin
        if (dmem_req) begin
          dreq_n++;
          chk("dmem_we", 64'(dmem_we), 64'(t.wr));
          dmem_ack = (dseen >= t.dw);
          dseen++;
        end else begin
          dmem_ack = ($urandom_range(0, 1) == 1);
        end
        if (rf_we)   rf_n++;
        if (irq_ack) ack_n++;
        // Stray acks outside FETCH must be ignored.
        imem_ack = ($urandom_range(0, 3) == 0);
        @(negedge clk); cyc++;
      end
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL timeout: no return to fetch at pc %0h expected within 64 cycles", pc);
    end
  endtask

  task automatic step(input ins_t t, output int cyc, output int rf_n, output int ack_n);
    int dreq_n, e_cyc, e_rf, e_ack, e_dreq;
    run_instr(t, cyc, rf_n, ack_n, dreq_n);
    model_step(t, e_cyc, e_rf, e_ack, e_dreq);
    chk("cycles",   64'(cyc),     64'(e_cyc));
    chk("rf_we_n",  64'(rf_n),    64'(e_rf));
    chk("irq_ack_n",64'(ack_n),   64'(e_ack));
    chk("dreq_n",   64'(dreq_n),  64'(e_dreq));
    chk("pc",       64'(pc),      64'(m_pc));
    chk("epc",      64'(epc),     64'(m_epc));
    chk("ie",       64'(ie),      64'(m_ie));
    chk("instret",  64'(instret), 64'(m_instret));
    chk("instret2", 64'(w_instret), 64'(m_instret[1:0]));
    chk("halted",   64'(halted),  64'(t.halt));
  endtask

  function automatic ins_t mk(input logic [5:0] f, input logic [31:0] tgt,
                              input int iw, input int dw, input logic irq_v);
    ins_t t;
    {t.rd, t.wr, t.wb, t.halt, t.iret, t.br} = f;
    t.target = tgt; t.iw = iw; t.dw = dw; t.irq = irq_v;
    return t;
  endfunction

  // ---------------- test sequence ----------------
  vec_t tbl[11];
  ins_t t;
  int cyc, rf_n, ack_n;

  initial begin
    // flags = {rd, wr, wb, halt, iret, br}
    tbl[0]  = '{mk(6'b001000, 32'h0,  0, 0, 1'b0), 4, 1, 0, 32'h004};
    tbl[1]  = '{mk(6'b100000, 32'h0,  0, 3, 1'b0), 8, 1, 0, 32'h008};
    tbl[2]  = '{mk(6'b010000, 32'h0,  0, 0, 1'b0), 4, 0, 0, 32'h00C};
    tbl[3]  = '{mk(6'b000000, 32'h0,  2, 0, 1'b0), 5, 0, 0, 32'h010};
    tbl[4]  = '{mk(6'b001000, 32'h0,  0, 0, 1'b1), 5, 1, 1, 32'h100};
    tbl[5]  = '{mk(6'b000000, 32'h0,  0, 0, 1'b1), 3, 0, 0, 32'h104};
    tbl[6]  = '{mk(6'b000001, 32'h40, 0, 0, 1'b0), 3, 0, 0, 32'h040};
    tbl[7]  = '{mk(6'b000011, 32'h80, 0, 0, 1'b1), 3, 0, 0, 32'h014};
    tbl[8]  = '{mk(6'b000000, 32'h0,  0, 0, 1'b1), 4, 0, 1, 32'h100};
    tbl[9]  = '{mk(6'b110000, 32'h0,  0, 1, 1'b0), 6, 1, 0, 32'h104};
    tbl[10] = '{mk(6'b000010, 32'h0,  0, 0, 1'b0), 3, 0, 0, 32'h018};

    reset = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'h0;
    dec_mem_rd = 1'b0; dec_mem_wr = 1'b0; dec_wb = 1'b0; dec_halt = 1'b0;
    dec_iret = 1'b0; br_taken = 1'b0; br_target = 32'h0; irq = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", 64'(imem_req), 64'(1'b0));
    chk("rst_dmem_req", 64'(dmem_req), 64'(1'b0));
    chk("rst_rf_we",    64'(rf_we),    64'(1'b0));
    chk("rst_irq_ack",  64'(irq_ack),  64'(1'b0));
    chk("rst_halted",   64'(halted),   64'(1'b0));
    chk("rst_pc",       64'(pc),       64'(32'h0));
    chk("rst_ir",       64'(ir),       64'(32'h0));
    chk("rst_epc",      64'(epc),      64'(32'h0));
    chk("rst_ie",       64'(ie),       64'(1'b1));
    chk("rst_instret",  64'(instret),  64'(32'h0));
    reset = 1'b1;
    model_reset();
    #1;
    chk("rel_imem_req", 64'(imem_req), 64'(1'b1));
    chk("rel_imem_addr",64'(imem_addr),64'(32'h0));

    // Table-driven directed vectors.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].ins, cyc, rf_n, ack_n);
      chk("tbl_cycles",  64'(cyc),   64'(tbl[i].e_cyc));
      chk("tbl_rf_we",   64'(rf_n),  64'(tbl[i].e_rf));
      chk("tbl_irq_ack", 64'(ack_n), 64'(tbl[i].e_ack));
      chk("tbl_pc",      64'(pc),    64'(tbl[i].e_pc));
      if (i == 2) chk("cnt_all_ones", 64'(w_instret), 64'(2'b11));
      if (i == 3) chk("cnt_wrap",     64'(w_instret), 64'(2'b00));
      if (i == 4) begin
        chk("irq_epc", 64'(epc), 64'(32'h14));
        chk("irq_ie",  64'(ie),  64'(1'b0));
      end
    end

    // Halt at 0x20, then leave through an interrupt.
    step(mk(6'b000000, 32'h0, 0, 0, 1'b0), cyc, rf_n, ack_n);
    step(mk(6'b000000, 32'h0, 0, 0, 1'b0), cyc, rf_n, ack_n);
    step(mk(6'b000100, 32'h0, 0, 0, 1'b0), cyc, rf_n, ack_n);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("halt_stay",    64'(halted),  64'(1'b1));
      chk("halt_pc",      64'(pc),      64'(32'h20));
      chk("halt_instret", 64'(instret), 64'(m_instret));
    end
    irq = 1'b1;
    @(negedge clk);
    chk("halt_irq_ack", 64'(irq_ack), 64'(1'b1));
    chk("halt_exit",    64'(halted),  64'(1'b0));
    @(negedge clk);
    irq = 1'b0;
    chk("halt_fetch_req", 64'(imem_req),  64'(1'b1));
    chk("halt_fetch_pc",  64'(imem_addr), 64'(32'h100));
    chk("halt_epc",       64'(epc),       64'(32'h24));
    chk("halt_ie",        64'(ie),        64'(1'b0));
    m_epc = 32'h24; m_pc = IRQ_VEC; m_ie = 1'b0;
    exp_q.push_back(IRQ_VEC);

    // Halt with interrupts disabled: irq must be ignored.
    step(mk(6'b000100, 32'h0, 1, 0, 1'b0), cyc, rf_n, ack_n);
    irq = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("halt_masked",     64'(halted),  64'(1'b1));
      chk("halt_masked_ack", 64'(irq_ack), 64'(1'b0));
    end
    irq = 1'b0;

    // Reset out of HALT, one instruction, then reset mid-FETCH.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    step(mk(6'b001000, 32'h0, 0, 0, 1'b0), cyc, rf_n, ack_n);
    repeat (2) @(negedge clk);
    chk("pre_rst_req",  64'(imem_req),  64'(1'b1));
    chk("pre_rst_addr", 64'(imem_addr), 64'(32'h4));
    reset = 1'b0;
    #1;
    chk("mid_rst_pc",      64'(pc),       64'(32'h0));
    chk("mid_rst_instret", 64'(instret),  64'(32'h0));
    chk("mid_rst_req",     64'(imem_req), 64'(1'b0));
    chk("mid_rst_rf_we",   64'(rf_we),    64'(1'b0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_req",   64'(imem_req),  64'(1'b1));
    chk("post_rst_addr",  64'(imem_addr), 64'(32'h0));
    chk("post_rst_rf_we", 64'(rf_we),     64'(1'b0));
    model_reset();

    // Randomized instruction stream against the reference model.
    for (int n = 0; n < 150; n++) begin
      t.rd     = ($urandom_range(0, 3) == 0);
      t.wr     = ($urandom_range(0, 3) == 0);
      t.wb     = ($urandom_range(0, 1) == 1);
      t.halt   = 1'b0;
      t.iret   = ($urandom_range(0, 7) == 0);
      t.br     = ($urandom_range(0, 3) == 0);
      t.target = $urandom & 32'hFFFF_FFFC;
      t.iw     = $urandom_range(0, 3);
      t.dw     = $urandom_range(0, 3);
      t.irq    = ($urandom_range(0, 2) == 0);
      step(t, cyc, rf_n, ack_n);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
